// File: rtl/eth_sw_pkg.sv
// Shared types and constants for the switch egress path: framer FSM states,
// the output buffer entry layout and the read-issue budget helper.
package eth_sw_pkg;

    localparam int HDR_W  = 8;
    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } frm_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              sof;
        logic              eof;
    } buf_entry_t;

    // A read may be issued when the byte it returns next cycle is sure of a
    // slot: entries held plus the read in flight, less the entry leaving now.
    function automatic logic issue_ok(input logic [1:0] buf_cnt,
                                      input logic       inflight,
                                      input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        return (occ < 3'd2);
    endfunction

endpackage

// File: rtl/eth_skid_buf2.sv
// Two-entry output buffer. The head entry always lives in its own register so
// the downstream interface is driven straight from flops.
module eth_skid_buf2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         valid_o,
    output logic [1:0]   cnt_o
);

    logic [W-1:0] head_q;
    logic [W-1:0] head_d;
    logic [W-1:0] tail_q;
    logic [W-1:0] tail_d;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         valid_q;
    logic         valid_d;
    logic         pop_s;

    assign pop_s = pop_i && valid_q;

    // Next-state: shift entries toward the head on pop, fill the first free slot on push
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_data_i;
                    cnt_d  = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    tail_d = push_data_i;
                    cnt_d  = 2'd2;
                end else begin
                    cnt_d  = cnt_q;
                end
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = {W{1'b0}};
                end else begin
                    head_d = {W{1'b0}};
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end else begin
                    head_d = push_data_i;
                end
            end
            default: begin
                head_d = head_q;
                tail_d = tail_q;
                cnt_d  = cnt_q;
            end
        endcase
        valid_d = (cnt_d != 2'd0);
    end

    // Buffer state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= {W{1'b0}};
            tail_q  <= {W{1'b0}};
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/eth_egress_framer.sv
// Egress framer: drains length-prefixed frames from the port byte FIFO, drops
// the length header and presents payload bytes with sof/eof on a valid/ready
// interface. A 2-entry buffer hides the FIFO's one-cycle read latency.
module eth_egress_framer
    import eth_sw_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              len_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    frm_state_e       state_q;
    frm_state_e       state_d;
    logic [HDR_W-1:0] rem_q;
    logic [HDR_W-1:0] rem_d;
    logic             first_q;
    logic             first_d;
    logic             inflight_q;
    logic             len_err_q;
    logic             len_err_d;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] frame_cnt_d;

    logic             rd_en_s;
    logic             pop_s;
    logic             push_s;
    buf_entry_t       push_entry_s;
    buf_entry_t       head_s;
    logic             buf_valid_s;
    logic [1:0]       buf_cnt_s;

    assign pop_s = buf_valid_s && tx_ready;

    // Read issue: crediting the pop leaving this cycle is what lets a byte
    // stream every cycle; reads are held off entirely while in reset.
    always_comb begin
        rd_en_s = 1'b0;
        if (reset_n && !fifo_empty) begin
            rd_en_s = issue_ok(buf_cnt_s, inflight_q, pop_s);
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // FSM state and datapath registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_HDR;
            rem_q       <= {HDR_W{1'b0}};
            first_q     <= 1'b0;
            inflight_q  <= 1'b0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            inflight_q  <= rd_en_s;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next state: a captured byte advances HDR->BODY on a nonzero length, BODY->HDR on the last byte
    always_comb begin
        state_d = state_q;
        if (inflight_q) begin
            case (state_q)
                ST_HDR: begin
                    if (fifo_data != {DATA_W{1'b0}}) begin
                        state_d = ST_BODY;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
                ST_BODY: begin
                    if (rem_q == 8'd1) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: header load / length error, or payload push with frame markers
    always_comb begin
        push_s       = 1'b0;
        push_entry_s = '{data: {BYTE_W{1'b0}}, sof: 1'b0, eof: 1'b0};
        len_err_d    = 1'b0;
        rem_d        = rem_q;
        first_d      = first_q;
        if (inflight_q) begin
            case (state_q)
                ST_HDR: begin
                    if (fifo_data == {DATA_W{1'b0}}) begin
                        len_err_d = 1'b1;
                    end else begin
                        rem_d   = fifo_data;
                        first_d = 1'b1;
                    end
                end
                ST_BODY: begin
                    push_s            = 1'b1;
                    push_entry_s.data = fifo_data;
                    push_entry_s.sof  = first_q;
                    push_entry_s.eof  = (rem_q == 8'd1);
                    first_d           = 1'b0;
                    rem_d             = rem_q - 8'd1;
                end
                default: begin
                    push_s = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Sent-frame counter advances when the eof byte is taken downstream
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (pop_s && head_s.eof) begin
            frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    eth_skid_buf2 #(
        .W($bits(buf_entry_t))
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .valid_o     (buf_valid_s),
        .cnt_o       (buf_cnt_s)
    );

    assign fifo_rd_en = rd_en_s;
    assign tx_valid   = buf_valid_s;
    assign tx_data    = head_s.data;
    assign tx_sof     = head_s.sof;
    assign tx_eof     = head_s.eof;
    assign len_err    = len_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
